idli_iss_m: RTL
===============

# idli_iss_m

Issue controller between decode and the execution unit. Buffers decoded ops in a small queue and collects each op's 16b immediate from the 4b SQI memory stream. Releases an op to execute only when its immediate is complete. Replays the captured immediate one nibble per cycle in lock-step with the execution unit's four-cycle nibble counter.

## Interface
Parameters:
- DEPTH, default 2: queue entries; power of two, at least 2.

Ports:
- i_iss_gck  in  1  gated clock.
- i_iss_rst_n  in  1  reset; asynchronous, active-low.
- i_iss_op  in  op_t  decoded op from decode.
- i_iss_op_vld  in  1  decode op valid.
- o_iss_op_acp  out  1  queue can take an op this cycle.
- i_iss_imm  in  sqi_data_t  immediate nibble from memory.
- i_iss_imm_vld  in  1  immediate nibble valid.
- o_iss_imm_acp  out  1  a queued entry is awaiting immediate nibbles.
- o_iss_ex_op  out  op_t  head op to execute.
- o_iss_ex_op_vld  out  1  head op ready (immediate complete or not needed).
- i_iss_ex_op_acp  in  1  execute accepts; high when execute is idle or on its final nibble cycle.
- o_iss_ex_imm  out  sqi_data_t  immediate nibble for the current execute cycle.
- i_iss_flush  in  1  redirect; discard all queued ops.

## Operation
- Entry contents: op, 16b imm, 2b imm_cnt, imm_done. imm_done=1 on enqueue if op.rhs_src != RHS_SRC_IMM.
- Enqueue on i_iss_op_vld && o_iss_op_acp.
  - o_iss_op_acp = !full && !i_iss_flush.
- Immediate capture:
  - The oldest entry with imm_done=0 takes nibble imm[4*imm_cnt +: 4] on i_iss_imm_vld && o_iss_imm_acp.
  - Capture order is LSB first. imm_cnt increments; imm_done sets when imm_cnt wraps 3->0.
  - Only entries enqueued in an earlier cycle can capture. A nibble arriving with o_iss_imm_acp=0 is dropped.
- Issue:
  - o_iss_ex_op_vld = !empty && head.imm_done && !i_iss_flush. o_iss_ex_op = head.op.
  - A transfer occurs on vld && i_iss_ex_op_acp. It pops the head, loads exec_imm_q with head.imm, clears phase_q to 0 and sets run_q.
- Replay FSM, states IDLE (run_q=0) and RUN(phase 0..3):
  - o_iss_ex_imm = exec_imm_q[4*phase_q +: 4] in RUN, exec_imm_q[3:0] in IDLE.
  - RUN(p<3) -> RUN(p+1).
  - RUN(3) -> RUN(0) if a transfer occurs that cycle, else IDLE.
  - IDLE -> RUN(0) on transfer.
- Flush:
  - All entries invalidated next edge. A same-cycle enqueue is blocked; a same-cycle transfer is suppressed.
  - An op already handed to execute completes: the replay FSM is unaffected and finishes its phases.
- Simultaneous enqueue and pop when full: not possible (acp low when full). Enqueue and pop when 1 entry: count unchanged.
- Pointers wrap modulo DEPTH; count has log2(DEPTH)+1 bits.

## Timing
- Reset values:
  - Queue empty, so o_iss_op_acp=1 (with flush low).
  - o_iss_ex_op_vld=0, o_iss_imm_acp=0.
  - run_q=0, phase_q=0, exec_imm_q=0, so o_iss_ex_imm=0.
- Reset mid-operation clears the queue and the replay FSM immediately (asynchronous).
- Latency:
  - Op without immediate: enqueue edge N, o_iss_ex_op_vld high cycle N+1.
  - Op with immediate: four nibbles at cycles N+1..N+4, vld high cycle N+5 at the earliest.
  - After transfer at edge T, nibbles 0..3 appear at cycles T+1..T+4, aligned with execute ctr 0..3.
- Back-to-back transfers every 4 cycles with no bubble when the next head is ready at RUN(3).
- All outputs are combinational from flops except o_iss_op_acp and o_iss_ex_op_vld, which also depend on i_iss_flush.

## Structure
- idli_pkg additions: iss_ent_t struct (op_t op; logic [15:0] imm; logic [1:0] imm_cnt; logic imm_done).
- Sub-module idli_iss_q_m holds the DEPTH-entry circular queue, pointers, count, full/empty and the oldest-incomplete select. It exposes a head entry plus push/pop/capture/flush controls.
- idli_iss_m contains the queue instance, the handshakes and the replay FSM.

## Test plan
- Enqueue op with rhs_src=REG, ex_acp=1 -> vld cycle after enqueue; transfer; o_iss_ex_imm=0 thereafter.
- Enqueue op with rhs_src=IMM, nibbles 0x4,0x3,0x2,0x1 -> vld only after the 4th nibble; after transfer o_iss_ex_imm = 4,3,2,1 on the next four cycles.
- Fill 2 entries with ex_acp=0 -> o_iss_op_acp=0; raise ex_acp for one cycle -> acp=1 next cycle and head advances.
- Two IMM ops queued (0xBEEF then 0x1234), nibbles streamed continuously -> first 4 nibbles go to entry 0, next 4 to entry 1; replays F,E,E,B then 4,3,2,1 back-to-back with no bubble.
- Flush at RUN(1) with 2 queued and a same-cycle enqueue -> queue empty next cycle, enqueue dropped, phases 2,3 still replayed, then IDLE.
- Assert reset at RUN(2) -> outputs immediately at reset values; after release, a fresh op issues normally.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types for the idli core: decoded op format, SQI nibble type and the
// issue-queue entry layout.
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [1:0] {
        RHS_SRC_REG  = 2'd0,
        RHS_SRC_IMM  = 2'd1,
        RHS_SRC_PC   = 2'd2,
        RHS_SRC_ZERO = 2'd3
    } rhs_src_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] dst;
        logic [2:0] lhs;
        logic [2:0] rhs;
        rhs_src_t   rhs_src;
    } op_t;

    typedef struct packed {
        op_t        op;
        logic [15:0] imm;
        logic [1:0] imm_cnt;
        logic       imm_done;
    } iss_ent_t;

    typedef enum logic {
        ISS_IDLE = 1'b0,
        ISS_RUN  = 1'b1
    } iss_state_t;

    // Fresh entry: ops that never read an immediate are born complete.
    function automatic iss_ent_t new_ent(input op_t op);
        iss_ent_t e;
        e.op       = op;
        e.imm      = '0;
        e.imm_cnt  = '0;
        e.imm_done = (op.rhs_src != RHS_SRC_IMM);
        return e;
    endfunction

endpackage

// File: rtl/idli_iss_q_m.sv
// Circular issue queue: holds decoded ops and steers incoming immediate
// nibbles to the oldest entry whose immediate is still incomplete.
module idli_iss_q_m
    import idli_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        i_gck,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  op_t         i_push_op,
    input  logic        i_pop,
    input  logic        i_cap,
    input  sqi_data_t   i_cap_data,
    input  logic        i_flush,
    output op_t         o_head_op,
    output logic [15:0] o_head_imm,
    output logic        o_head_rdy,
    output logic        o_full,
    output logic        o_empty,
    output logic        o_cap_rdy
);

    localparam int PW = $clog2(DEPTH);

    iss_ent_t        ent_q [DEPTH];
    iss_ent_t        ent_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic [PW-1:0]   cap_idx;
    logic            cap_found;

    // Walk from the head so the oldest incomplete entry wins.
    always_comb begin
        cap_idx   = '0;
        cap_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!cap_found && ((PW+1)'(i) < cnt_q) &&
                !ent_q[rd_ptr_q + PW'(i)].imm_done) begin
                cap_found = 1'b1;
                cap_idx   = rd_ptr_q + PW'(i);
            end
        end
    end

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        ent_d    = ent_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        if (i_cap && cap_found) begin
            ent_d[cap_idx].imm[{ent_q[cap_idx].imm_cnt, 2'b00} +: 4] = i_cap_data;
            ent_d[cap_idx].imm_cnt = ent_q[cap_idx].imm_cnt + 2'd1;
            if (ent_q[cap_idx].imm_cnt == 2'd3) begin
                ent_d[cap_idx].imm_done = 1'b1;
            end
        end

        if (i_push) begin
            ent_d[wr_ptr_q] = new_ent(i_push_op);
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end

        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        cnt_d = cnt_q + (PW+1)'(i_push) - (PW+1)'(i_pop);

        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // NOTE: the entry array is reset too, so head outputs are never X while the queue is empty.
    always_ff @(posedge i_gck or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            ent_q    <= ent_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_head_op  = ent_q[rd_ptr_q].op;
    assign o_head_imm = ent_q[rd_ptr_q].imm;
    assign o_head_rdy = ent_q[rd_ptr_q].imm_done;
    assign o_full     = (cnt_q == (PW+1)'(DEPTH));
    assign o_empty    = (cnt_q == '0);
    assign o_cap_rdy  = cap_found;

endmodule

// File: rtl/idli_iss_m.sv
// Issue controller: queues decoded ops, gathers their immediates from the SQI
// stream and replays the immediate one nibble per execute cycle.
module idli_iss_m
    import idli_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      i_iss_gck,
    input  logic      i_iss_rst_n,
    input  op_t       i_iss_op,
    input  logic      i_iss_op_vld,
    output logic      o_iss_op_acp,
    input  sqi_data_t i_iss_imm,
    input  logic      i_iss_imm_vld,
    output logic      o_iss_imm_acp,
    output op_t       o_iss_ex_op,
    output logic      o_iss_ex_op_vld,
    input  logic      i_iss_ex_op_acp,
    output sqi_data_t o_iss_ex_imm,
    input  logic      i_iss_flush
);

    op_t         head_op;
    logic [15:0] head_imm;
    logic        head_rdy;
    logic        full, empty, cap_rdy;
    logic        push, xfer;

    iss_state_t  state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] exec_imm_q, exec_imm_d;

    assign o_iss_op_acp    = !full && !i_iss_flush;
    assign push            = i_iss_op_vld && o_iss_op_acp;
    assign o_iss_imm_acp   = cap_rdy;
    assign o_iss_ex_op_vld = !empty && head_rdy && !i_iss_flush;
    assign o_iss_ex_op     = head_op;
    assign xfer            = o_iss_ex_op_vld && i_iss_ex_op_acp;

    idli_iss_q_m #(.DEPTH(DEPTH)) u_q (
        .i_gck      (i_iss_gck),
        .i_rst_n    (i_iss_rst_n),
        .i_push     (push),
        .i_push_op  (i_iss_op),
        .i_pop      (xfer),
        .i_cap      (i_iss_imm_vld && cap_rdy),
        .i_cap_data (i_iss_imm),
        .i_flush    (i_iss_flush),
        .o_head_op  (head_op),
        .o_head_imm (head_imm),
        .o_head_rdy (head_rdy),
        .o_full     (full),
        .o_empty    (empty),
        .o_cap_rdy  (cap_rdy)
    );

    // Flush never touches the replay: an op already handed over finishes.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        exec_imm_d = exec_imm_q;

        case (state_q)
            ISS_RUN: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    state_d = ISS_IDLE;
                end
            end
            default: ;
        endcase

        if (xfer) begin
            state_d    = ISS_RUN;
            phase_d    = 2'd0;
            exec_imm_d = head_imm;
        end
    end

    always_ff @(posedge i_iss_gck or negedge i_iss_rst_n) begin
        if (!i_iss_rst_n) begin
            state_q    <= ISS_IDLE;
            phase_q    <= 2'd0;
            exec_imm_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            exec_imm_q <= exec_imm_d;
        end
    end

    assign o_iss_ex_imm = (state_q == ISS_RUN) ? exec_imm_q[{phase_q, 2'b00} +: 4]
                                               : exec_imm_q[3:0];

endmodule
